// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-cache handshake, control from
// decode/execute, and the IF/ID pipeline register outputs.
//   master : the fetch stage (drives ic_req/ic_addr and IF/ID outputs)
//   slave  : the environment (cache, decode, execute)
interface fetch_stage_if;
  logic        stall_D;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic        ic_valid;
  logic [31:0] ic_instr;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc_plus4_D;
  logic        valid_D;

  modport master (
    input  stall_D, redirect, redirect_pc, ic_ready, ic_valid, ic_instr,
    output ic_req, ic_addr, instr_D, pc_D, pc_plus4_D, valid_D
  );

  modport slave (
    output stall_D, redirect, redirect_pc, ic_ready, ic_valid, ic_instr,
    input  ic_req, ic_addr, instr_D, pc_D, pc_plus4_D, valid_D
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with one outstanding I-cache request.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_stage_if.master
//     stall_D, redirect, redirect_pc      - pipeline control in
//     ic_req/ic_addr/ic_ready             - cache request handshake
//     ic_valid/ic_instr                   - cache response
//     instr_D/pc_D/pc_plus4_D/valid_D     - registered IF/ID outputs
// A response arriving while decode is stalled is parked in a skid buffer
// (HOLD) until decode frees up. A redirect while a request is in flight
// sends the FSM to DROP so the stale response is discarded.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {ISSUE, WAIT, DROP, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;

  logic        decode_free;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] pc_f_plus4;
  logic [31:0] redirect_tgt;

  assign decode_free  = ~id_valid_q | ~bus.stall_D;
  assign pc_f_plus4   = pc_f_q + 32'd4;
  assign redirect_tgt = bus.redirect_pc & ~32'h0000_0003;

  // Request is qualified by rst so it is low during an asynchronous reset.
  assign bus.ic_req     = (state_q == ISSUE) & ~bus.redirect & ~rst;
  assign bus.ic_addr    = pc_f_q;
  assign bus.instr_D    = id_instr_q;
  assign bus.pc_D       = id_pc_q;
  assign bus.pc_plus4_D = id_pc4_q;
  assign bus.valid_D    = id_valid_q;

  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    skid_d        = skid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc4_d      = id_pc4_q;
    id_valid_d    = id_valid_q;
    deliver       = 1'b0;
    deliver_instr = bus.ic_instr;

    if (bus.redirect) begin
      // Redirect beats stall and any response arriving this cycle.
      pc_f_d     = redirect_tgt;
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      unique case (state_q)
        ISSUE:   state_d = ISSUE;
        WAIT:    state_d = bus.ic_valid ? ISSUE : DROP;
        DROP:    state_d = DROP;
        HOLD:    state_d = ISSUE;
        default: state_d = ISSUE;
      endcase
    end else begin
      unique case (state_q)
        ISSUE: begin
          if (bus.ic_ready) state_d = WAIT;
        end
        WAIT: begin
          if (bus.ic_valid) begin
            if (decode_free) begin
              deliver = 1'b1;
              state_d = ISSUE;
            end else begin
              skid_d  = bus.ic_instr;
              state_d = HOLD;
            end
          end
        end
        DROP: begin
          if (bus.ic_valid) state_d = ISSUE;
        end
        HOLD: begin
          if (!bus.stall_D) begin
            deliver       = 1'b1;
            deliver_instr = skid_q;
            state_d       = ISSUE;
          end
        end
        default: state_d = ISSUE;
      endcase

      if (deliver) begin
        id_instr_d = deliver_instr;
        id_pc_d    = pc_f_q;
        id_pc4_d   = pc_f_plus4;
        id_valid_d = 1'b1;
        pc_f_d     = pc_f_plus4;
      end else if (decode_free) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ISSUE;
      pc_f_q     <= RESET_PC;
      skid_q     <= '0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      skid_q     <= skid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.stall_D = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.ic_ready = 1'b0; bus.ic_valid = 1'b0; bus.ic_instr = '0;
    #1 rst = 1'b1;
    #2;
    checks++; if (bus.ic_req !== 1'b0) begin failures++; $display("FAIL rst_ic_req got=%h exp=0", bus.ic_req); end
    checks++; if (bus.valid_D !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", bus.valid_D); end
    checks++; if (bus.instr_D !== 32'h13) begin failures++; $display("FAIL rst_instr got=%h exp=00000013", bus.instr_D); end
    checks++; if (bus.pc_D !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", bus.pc_D); end
    checks++; if (bus.pc_plus4_D !== 32'h0) begin failures++; $display("FAIL rst_pc4 got=%h exp=0", bus.pc_plus4_D); end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.ic_req !== 1'b1) begin failures++; $display("FAIL post_rst_req got=%h exp=1", bus.ic_req); end
    checks++; if (bus.ic_addr !== 32'h0) begin failures++; $display("FAIL post_rst_addr got=%h exp=0", bus.ic_addr); end
  endtask

  task automatic test_basic();
    bus.ic_ready = 1'b1;
    tick();
    bus.ic_ready = 1'b0; bus.ic_valid = 1'b1; bus.ic_instr = 32'h00500093;
    #1;
    checks++; if (bus.ic_req !== 1'b0) begin failures++; $display("FAIL wait_req got=%h exp=0", bus.ic_req); end
    tick();
    bus.ic_valid = 1'b0;
    #1;
    checks++; if (bus.instr_D !== 32'h00500093) begin failures++; $display("FAIL basic_instr got=%h exp=00500093", bus.instr_D); end
    checks++; if (bus.pc_D !== 32'h0) begin failures++; $display("FAIL basic_pc got=%h exp=0", bus.pc_D); end
    checks++; if (bus.pc_plus4_D !== 32'h4) begin failures++; $display("FAIL basic_pc4 got=%h exp=4", bus.pc_plus4_D); end
    checks++; if (bus.valid_D !== 1'b1) begin failures++; $display("FAIL basic_valid got=%h exp=1", bus.valid_D); end
    checks++; if (bus.ic_addr !== 32'h4) begin failures++; $display("FAIL basic_next_addr got=%h exp=4", bus.ic_addr); end
    checks++; if (bus.ic_req !== 1'b1) begin failures++; $display("FAIL basic_next_req got=%h exp=1", bus.ic_req); end
  endtask

  task automatic test_stall();
    bus.stall_D = 1'b1; bus.ic_ready = 1'b1;
    tick();
    bus.ic_ready = 1'b0;
    tick();
    bus.ic_valid = 1'b1; bus.ic_instr = 32'h00A00113;
    tick();
    bus.ic_valid = 1'b0;
    #1;
    checks++; if (bus.instr_D !== 32'h00500093) begin failures++; $display("FAIL stall_instr got=%h exp=00500093", bus.instr_D); end
    checks++; if (bus.pc_D !== 32'h0) begin failures++; $display("FAIL stall_pc got=%h exp=0", bus.pc_D); end
    checks++; if (bus.valid_D !== 1'b1) begin failures++; $display("FAIL stall_valid got=%h exp=1", bus.valid_D); end
    checks++; if (bus.ic_req !== 1'b0) begin failures++; $display("FAIL hold_req got=%h exp=0", bus.ic_req); end
    bus.stall_D = 1'b0;
    tick();
    checks++; if (bus.instr_D !== 32'h00A00113) begin failures++; $display("FAIL skid_instr got=%h exp=00a00113", bus.instr_D); end
    checks++; if (bus.pc_D !== 32'h4) begin failures++; $display("FAIL skid_pc got=%h exp=4", bus.pc_D); end
    checks++; if (bus.pc_plus4_D !== 32'h8) begin failures++; $display("FAIL skid_pc4 got=%h exp=8", bus.pc_plus4_D); end
    checks++; if (bus.ic_addr !== 32'h8) begin failures++; $display("FAIL skid_next_addr got=%h exp=8", bus.ic_addr); end
  endtask

  task automatic test_redirect_wait();
    bus.ic_ready = 1'b1;
    tick();
    checks++; if (bus.valid_D !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%h exp=0", bus.valid_D); end
    checks++; if (bus.instr_D !== 32'h13) begin failures++; $display("FAIL bubble_instr got=%h exp=00000013", bus.instr_D); end
    bus.ic_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.ic_req !== 1'b0) begin failures++; $display("FAIL drop_req got=%h exp=0", bus.ic_req); end
    tick();
    bus.ic_valid = 1'b1; bus.ic_instr = 32'hDEAD_BEEF;
    tick();
    bus.ic_valid = 1'b0;
    #1;
    checks++; if (bus.valid_D !== 1'b0) begin failures++; $display("FAIL drop_valid got=%h exp=0", bus.valid_D); end
    checks++; if (bus.instr_D !== 32'h13) begin failures++; $display("FAIL drop_instr got=%h exp=00000013", bus.instr_D); end
    checks++; if (bus.ic_addr !== 32'h100) begin failures++; $display("FAIL drop_next_addr got=%h exp=00000100", bus.ic_addr); end
    checks++; if (bus.ic_req !== 1'b1) begin failures++; $display("FAIL drop_next_req got=%h exp=1", bus.ic_req); end
  endtask

  task automatic test_redirect_stall_valid();
    bus.ic_ready = 1'b1;
    tick();
    bus.ic_ready = 1'b0; bus.ic_valid = 1'b1; bus.ic_instr = 32'h1111_1111;
    tick();
    checks++; if (bus.pc_D !== 32'h100) begin failures++; $display("FAIL rsv_pre_pc got=%h exp=00000100", bus.pc_D); end
    bus.ic_valid = 1'b0; bus.stall_D = 1'b1; bus.ic_ready = 1'b1;
    tick();
    bus.ic_ready = 1'b0; bus.ic_valid = 1'b1; bus.ic_instr = 32'h2222_2222;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
    tick();
    bus.redirect = 1'b0; bus.ic_valid = 1'b0; bus.stall_D = 1'b0;
    #1;
    checks++; if (bus.valid_D !== 1'b0) begin failures++; $display("FAIL rsv_valid got=%h exp=0", bus.valid_D); end
    checks++; if (bus.instr_D !== 32'h13) begin failures++; $display("FAIL rsv_instr got=%h exp=00000013", bus.instr_D); end
    checks++; if (bus.pc_D !== 32'h100) begin failures++; $display("FAIL rsv_pc_hold got=%h exp=00000100", bus.pc_D); end
    checks++; if (bus.ic_addr !== 32'h200) begin failures++; $display("FAIL rsv_next_addr got=%h exp=00000200", bus.ic_addr); end
    checks++; if (bus.ic_req !== 1'b1) begin failures++; $display("FAIL rsv_next_req got=%h exp=1", bus.ic_req); end
  endtask

  task automatic test_wrap();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF; bus.ic_ready = 1'b1;
    #1;
    checks++; if (bus.ic_req !== 1'b0) begin failures++; $display("FAIL issue_redir_req got=%h exp=0", bus.ic_req); end
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.ic_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", bus.ic_addr); end
    tick();
    bus.ic_ready = 1'b0; bus.ic_valid = 1'b1; bus.ic_instr = 32'h3333_3333;
    tick();
    bus.ic_valid = 1'b0;
    #1;
    checks++; if (bus.pc_D !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", bus.pc_D); end
    checks++; if (bus.pc_plus4_D !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=0", bus.pc_plus4_D); end
    checks++; if (bus.ic_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr got=%h exp=0", bus.ic_addr); end
    checks++; if (bus.instr_D !== 32'h3333_3333) begin failures++; $display("FAIL wrap_instr got=%h exp=33333333", bus.instr_D); end
  endtask

  task automatic test_reset_in_hold();
    bus.stall_D = 1'b1; bus.ic_ready = 1'b1;
    tick();
    bus.ic_ready = 1'b0; bus.ic_valid = 1'b1; bus.ic_instr = 32'h4444_4444;
    tick();
    bus.ic_valid = 1'b0;
    #1;
    checks++; if (bus.valid_D !== 1'b1) begin failures++; $display("FAIL hold2_valid got=%h exp=1", bus.valid_D); end
    rst = 1'b1;
    #1;
    checks++; if (bus.valid_D !== 1'b0) begin failures++; $display("FAIL async_valid got=%h exp=0", bus.valid_D); end
    checks++; if (bus.instr_D !== 32'h13) begin failures++; $display("FAIL async_instr got=%h exp=00000013", bus.instr_D); end
    checks++; if (bus.pc_D !== 32'h0) begin failures++; $display("FAIL async_pc got=%h exp=0", bus.pc_D); end
    checks++; if (bus.ic_req !== 1'b0) begin failures++; $display("FAIL async_req got=%h exp=0", bus.ic_req); end
    tick();
    rst = 1'b0; bus.stall_D = 1'b0;
    #1;
    checks++; if (bus.ic_req !== 1'b1) begin failures++; $display("FAIL rel_req got=%h exp=1", bus.ic_req); end
    checks++; if (bus.ic_addr !== 32'h0) begin failures++; $display("FAIL rel_addr got=%h exp=0", bus.ic_addr); end
    bus.ic_ready = 1'b1;
    tick();
    bus.ic_ready = 1'b0; bus.ic_valid = 1'b1; bus.ic_instr = 32'h5555_5555;
    tick();
    bus.ic_valid = 1'b0;
    #1;
    checks++; if (bus.instr_D !== 32'h5555_5555) begin failures++; $display("FAIL rel_instr got=%h exp=55555555", bus.instr_D); end
    checks++; if (bus.pc_D !== 32'h0) begin failures++; $display("FAIL rel_pc got=%h exp=0", bus.pc_D); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_stall_valid();
    test_wrap();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction driven to decode (addi x0,x0,0).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall_D  in  1  decode cannot accept; hold the IF/ID outputs.
REQ-006 redirect  in  1  taken branch/jump from execute; flush and refetch.
REQ-007 redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 00.
REQ-008 ic_req  out  1  instruction-cache request valid.
REQ-009 ic_addr  out  32  request address, equal to pc_F.
REQ-010 ic_ready  in  1  cache accepts request this cycle.
REQ-011 ic_valid  in  1  response valid, at least 1 cycle after acceptance; at most one outstanding.
REQ-012 ic_instr  in  32  response instruction word.
REQ-013 instr_D  out  32  registered instruction to decode.
REQ-014 pc_D  out  32  registered PC of instr_D.
REQ-015 pc_plus4_D  out  32  registered pc_D+4, modulo 2^32.
REQ-016 valid_D  out  1  instr_D is a real instruction.

Function
REQ-017 SHALL hold internal pc_F and a 3-bit-or-less FSM with states ISSUE, WAIT, DROP, HOLD, plus a 32-bit skid buffer.
REQ-018 ISSUE: ic_req=1 unless redirect or rst; on ic_req&ic_ready go WAIT.
REQ-019 WAIT: on ic_valid with decode free (valid_D=0 or stall_D=0), load instr_D=ic_instr, pc_D=pc_F, pc_plus4_D=pc_F+4, valid_D=1, pc_F+=4, go ISSUE.
REQ-020 WAIT: on ic_valid with decode stalled (valid_D=1 and stall_D=1), capture ic_instr in skid buffer, go HOLD; pc_F unchanged.
REQ-021 HOLD: ic_req=0; when stall_D=0 move buffer to IF/ID outputs (pc_D=pc_F), pc_F+=4, go ISSUE.
REQ-022 Decode free and no instruction delivered that cycle: valid_D=0, instr_D=NOP_INSTR; pc_D, pc_plus4_D hold.
REQ-023 stall_D=1 and valid_D=1 without redirect: instr_D, pc_D, pc_plus4_D, valid_D SHALL hold.
REQ-024 redirect has priority over stall_D and ic_valid: next cycle valid_D=0, instr_D=NOP_INSTR, pc_F={redirect_pc[31:2],2'b00}.
REQ-025 redirect in ISSUE: ic_req forced 0 that cycle, stay ISSUE.
REQ-026 redirect in WAIT without ic_valid: go DROP; same cycle as ic_valid: discard response, go ISSUE.
REQ-027 DROP: ic_req=0; on ic_valid discard response, go ISSUE; redirect in DROP updates pc_F only, stays DROP.
REQ-028 redirect in HOLD: discard skid buffer, go ISSUE.
REQ-029 pc_F+4 SHALL wrap 32'hFFFF_FFFC to 32'h0000_0000.
REQ-030 Latency: request accepted at cycle N, ic_valid at N+k, instr_D valid at N+k+1.
REQ-031 Throughput with zero-wait cache: one instruction per 2 cycles (ISSUE/WAIT); no speculative second request.

Reset
REQ-032 While rst=1 asynchronously: pc_F=RESET_PC, state=ISSUE, ic_req=0, valid_D=0, instr_D=NOP_INSTR, pc_D=0, pc_plus4_D=0, skid buffer cleared.
REQ-033 First cycle after rst deasserts: ic_req=1, ic_addr=RESET_PC.
REQ-034 rst during WAIT: in-flight response after reset SHALL be ignored only if it arrives while in ISSUE; bench SHALL not return responses across reset.

Verification
REQ-035 Reset, ic_ready=1, 1-cycle response 32'h00500093 -> ic_addr=0, then instr_D=32'h00500093, pc_D=0, pc_plus4_D=4, valid_D=1, next ic_addr=4.
REQ-036 valid_D=1, stall_D=1 for 3 cycles, response 32'h00A00113 arrives -> IF/ID outputs hold; after stall_D=0, instr_D=32'h00A00113, pc_D=4.
REQ-037 In WAIT, redirect with redirect_pc=32'h0000_0103, response 2 cycles later -> response discarded, valid_D=0, next ic_addr=32'h0000_0100.
REQ-038 redirect same cycle as ic_valid and stall_D=1 -> valid_D=0, instr_D=32'h00000013, next ic_addr=redirect target.
REQ-039 redirect_pc=32'hFFFF_FFFC, response delivered -> pc_D=32'hFFFF_FFFC, pc_plus4_D=0, next ic_addr=0.
REQ-040 rst asserted mid-HOLD -> outputs reset immediately without clock edge, buffer dropped, ic_addr=RESET_PC after release.
